// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared opcode, ALUOp, select and state encodings for the multi-cycle MIPS core
package mips_defs;

   localparam int OPC_WIDTH   = 6;
   localparam int ALUOP_WIDTH = 3;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;

   localparam logic [2:0] ALU_ADDU = 3'b000;
   localparam logic [2:0] ALU_SUBU = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_LUI  = 3'b100;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_RS     = 2'b11;

   localparam logic [1:0] ALUB_RT   = 2'b00;
   localparam logic [1:0] ALUB_FOUR = 2'b01;
   localparam logic [1:0] ALUB_ZEXT = 2'b10;
   localparam logic [1:0] ALUB_SEXT = 2'b11;

   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_EXEC_R   = 4'd3,
      ST_WB_R     = 4'd4,
      ST_EXEC_I   = 4'd5,
      ST_WB_I     = 4'd6,
      ST_MEM_ADDR = 4'd7,
      ST_MEM_RD   = 4'd8,
      ST_MEM_WB   = 4'd9,
      ST_MEM_WR   = 4'd10,
      ST_BRANCH   = 4'd11,
      ST_JUMP     = 4'd12,
      ST_JAL      = 4'd13,
      ST_JR       = 4'd14
   } state_e;

   typedef enum logic [3:0] {
      CLS_ILL = 4'd0,
      CLS_R   = 4'd1,
      CLS_JR  = 4'd2,
      CLS_I   = 4'd3,
      CLS_LW  = 4'd4,
      CLS_SW  = 4'd5,
      CLS_BEQ = 4'd6,
      CLS_J   = 4'd7,
      CLS_JAL = 4'd8
   } instr_cls_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - opcode/funct to instruction class and execute-step ALUOp
module mc_ctrl_decode
   import mips_defs::*;
(
   input  logic [OPC_WIDTH-1:0]   opcode,
   input  logic [OPC_WIDTH-1:0]   funct,
   output instr_cls_e             cls,
   output logic [ALUOP_WIDTH-1:0] exec_alu_op
);

   always_comb begin
      cls         = CLS_ILL;
      exec_alu_op = ALU_ADDU;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: cls = CLS_R;
               FN_SUBU: begin
                  cls         = CLS_R;
                  exec_alu_op = ALU_SUBU;
               end
               FN_JR:   cls = CLS_JR;
               default: cls = CLS_ILL;
            endcase
         end
         OP_ORI: begin
            cls         = CLS_I;
            exec_alu_op = ALU_OR;
         end
         OP_LUI: begin
            cls         = CLS_I;
            exec_alu_op = ALU_LUI;
         end
         OP_LW:   cls = CLS_LW;
         OP_SW:   cls = CLS_SW;
         OP_BEQ:  cls = CLS_BEQ;
         OP_J:    cls = CLS_J;
         OP_JAL:  cls = CLS_JAL;
         default: cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle control FSM sequencing the shared ALU, memory handshake and datapath selects
module mc_ctrl
   import mips_defs::*;
#(
   parameter int ALUOP_W = ALUOP_WIDTH,
   parameter int OPC_W   = OPC_WIDTH
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [OPC_W-1:0]   opcode,
   input  logic [OPC_W-1:0]   funct,
   input  logic               zero,
   input  logic               mem_ack,
   output logic               mem_req,
   output logic               mem_we,
   output logic               i_or_d,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               ext_shift,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               reg_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic               instr_done,
   output logic               illegal
);

   state_e                 state_q, state_d;
   logic                   illegal_q, illegal_d;
   instr_cls_e             cls;
   logic [ALUOP_WIDTH-1:0] exec_alu_op;
   logic [ALUOP_WIDTH-1:0] alu_op_c;

   mc_ctrl_decode u_decode (
      .opcode      (opcode),
      .funct       (funct),
      .cls         (cls),
      .exec_alu_op (exec_alu_op)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   assign alu_op = alu_op_c;

   always_comb begin
      state_d    = state_q;
      illegal_d  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = ALUB_RT;
      ext_shift  = 1'b0;
      alu_op_c   = ALU_ADDU;
      reg_write  = 1'b0;
      reg_dst    = REG_DST_RT;
      mem_to_reg = M2R_ALUOUT;
      // An illegal instruction retires in the cycle after DECODE, overlapping the next FETCH.
      instr_done = illegal_q;
      illegal    = illegal_q;

      case (state_q)
         ST_IDLE: state_d = ST_FETCH;

         ST_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = ALUB_FOUR;
            if (mem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end
         end

         ST_DECODE: begin
            alu_src_b = ALUB_SEXT;
            ext_shift = 1'b1;
            case (cls)
               CLS_R:   state_d = ST_EXEC_R;
               CLS_JR:  state_d = ST_JR;
               CLS_I:   state_d = ST_EXEC_I;
               CLS_LW,
               CLS_SW:  state_d = ST_MEM_ADDR;
               CLS_BEQ: state_d = ST_BRANCH;
               CLS_J:   state_d = ST_JUMP;
               CLS_JAL: state_d = ST_JAL;
               default: begin
                  state_d   = ST_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end

         ST_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_RT;
            alu_op_c  = exec_alu_op;
            state_d   = ST_WB_R;
         end

         ST_WB_R: begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RD;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end

         ST_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_ZEXT;
            alu_op_c  = exec_alu_op;
            state_d   = ST_WB_I;
         end

         ST_WB_I: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end

         ST_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_SEXT;
            state_d   = (cls == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
         end

         ST_MEM_RD: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ack) state_d = ST_MEM_WB;
         end

         ST_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_MDR;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end

         ST_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            i_or_d  = 1'b1;
            if (mem_ack) begin
               instr_done = 1'b1;
               state_d    = ST_FETCH;
            end
         end

         ST_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = ALUB_RT;
            alu_op_c   = ALU_SUBU;
            pc_src     = PC_SRC_ALUOUT;
            pc_write   = zero;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end

         ST_JUMP: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end

         // PC already holds PC+4 here, so the link value is taken straight from PC.
         ST_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RA;
            mem_to_reg = M2R_PC;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end

         ST_JR: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_RS;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed cycle-by-cycle bench for the multi-cycle control FSM
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode, funct;
   logic       zero, mem_ack;
   logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
   logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
   logic       alu_src_a, ext_shift, reg_write, instr_done, illegal;
   logic [2:0] alu_op;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ack    (mem_ack),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .i_or_d     (i_or_d),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .ext_shift  (ext_shift),
      .alu_op     (alu_op),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   logic [20:0] obs;
   assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                 ext_shift, alu_op, reg_write, reg_dst, mem_to_reg, instr_done, illegal};

   function automatic logic [20:0] mk(input logic req, we, iod, irw, pcw, input logic [1:0] pcs,
                                      input logic asa, input logic [1:0] asb, input logic ext,
                                      input logic [2:0] op, input logic rw, input logic [1:0] rd,
                                      input logic [1:0] m2r, input logic done, ill);
      return {req, we, iod, irw, pcw, pcs, asa, asb, ext, op, rw, rd, m2r, done, ill};
   endfunction

   logic [20:0] e_zero, e_fetch_ack, e_fetch_wait, e_fetch_wait_ill, e_decode;
   logic [20:0] e_exec_addu, e_exec_subu, e_wb_r, e_exec_ori, e_exec_lui, e_wb_i;
   logic [20:0] e_mem_addr, e_mem_rd, e_mem_wb, e_mem_wr_wait, e_mem_wr_ack;
   logic [20:0] e_br_t, e_br_n, e_jump, e_jal, e_jr;

   task automatic test_reset();
      reset_n = 1'b0; mem_ack = 1'b1; zero = 1'b0; opcode = 6'd0; funct = 6'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== e_zero) begin
         errors++; $display("FAIL reset_hold got=%h exp=%h", obs, e_zero);
      end
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== e_zero) begin
         errors++; $display("FAIL reset_idle got=%h exp=%h", obs, e_zero);
      end
   endtask

   task automatic test_addu();
      logic [20:0] ev [4];
      ev = '{e_fetch_ack, e_decode, e_exec_addu, e_wb_r};
      opcode = 6'b000000; funct = 6'b100001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); mem_ack = 1'b1; #1;
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL addu cyc%0d got=%h exp=%h", i + 1, obs, ev[i]);
         end
      end
   endtask

   task automatic test_rtype_itype();
      logic [20:0] ev [12];
      logic [5:0]  op [12];
      logic [5:0]  fn [12];
      ev = '{e_fetch_ack, e_decode, e_exec_subu, e_wb_r,
             e_fetch_ack, e_decode, e_exec_ori, e_wb_i,
             e_fetch_ack, e_decode, e_exec_lui, e_wb_i};
      op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0d, 6'h0d, 6'h0d, 6'h0f, 6'h0f, 6'h0f, 6'h0f};
      fn = '{6'h23, 6'h23, 6'h23, 6'h23, 6'h25, 6'h25, 6'h25, 6'h25, 6'h21, 6'h21, 6'h21, 6'h21};
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); mem_ack = 1'b1; opcode = op[i]; funct = fn[i]; #1;
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL subu_ori_lui cyc%0d got=%h exp=%h", i, obs, ev[i]);
         end
      end
   endtask

   task automatic test_lw_stall();
      logic [20:0] ev [7];
      logic        ak [7];
      ev = '{e_fetch_ack, e_decode, e_mem_addr, e_mem_rd, e_mem_rd, e_mem_rd, e_mem_wb};
      ak = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      opcode = 6'b100011; funct = 6'd0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); mem_ack = ak[i]; #1;
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL lw_stall cyc%0d got=%h exp=%h", i + 1, obs, ev[i]);
         end
      end
   endtask

   task automatic test_sw_fetch_stall();
      logic [20:0] ev [5];
      logic        ak [5];
      ev = '{e_fetch_wait, e_fetch_ack, e_decode, e_mem_addr, e_mem_wr_ack};
      ak = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      opcode = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); mem_ack = ak[i]; #1;
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL sw_fetch_stall cyc%0d got=%h exp=%h", i + 1, obs, ev[i]);
         end
      end
   endtask

   task automatic test_beq();
      logic [20:0] ev [6];
      logic        zv [6];
      ev = '{e_fetch_ack, e_decode, e_br_t, e_fetch_ack, e_decode, e_br_n};
      zv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      opcode = 6'b000100;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); mem_ack = 1'b1; zero = zv[i]; #1;
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL beq cyc%0d got=%h exp=%h", i, obs, ev[i]);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_jumps();
      logic [20:0] ev [9];
      logic [5:0]  op [9];
      logic [5:0]  fn [9];
      ev = '{e_fetch_ack, e_decode, e_jal, e_fetch_ack, e_decode, e_jr, e_fetch_ack, e_decode, e_jump};
      op = '{6'h03, 6'h03, 6'h03, 6'h00, 6'h00, 6'h00, 6'h02, 6'h02, 6'h02};
      fn = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h08, 6'h08, 6'h00, 6'h00, 6'h00};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); mem_ack = 1'b1; opcode = op[i]; funct = fn[i]; #1;
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL jal_jr_j cyc%0d got=%h exp=%h", i, obs, ev[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [20:0] ev [8];
      logic        ak [8];
      logic [5:0]  op [8];
      logic [5:0]  fn [8];
      ev = '{e_fetch_ack, e_decode, e_fetch_wait_ill, e_fetch_wait,
             e_fetch_ack, e_decode, e_fetch_wait_ill, e_fetch_wait};
      ak = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      op = '{6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h00, 6'h00, 6'h00, 6'h00};
      fn = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h20, 6'h20, 6'h20};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); mem_ack = ak[i]; opcode = op[i]; funct = fn[i]; #1;
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs, ev[i]);
         end
      end
   endtask

   task automatic test_reset_mid_store();
      logic [20:0] ev [5];
      logic        ak [5];
      ev = '{e_fetch_ack, e_decode, e_mem_addr, e_mem_wr_wait, e_mem_wr_wait};
      ak = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      opcode = 6'b101011; funct = 6'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); mem_ack = ak[i]; #1;
         checks++;
         if (obs !== ev[i]) begin
            errors++; $display("FAIL sw_pre_reset cyc%0d got=%h exp=%h", i + 1, obs, ev[i]);
         end
      end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== e_zero) begin
         errors++; $display("FAIL async_reset_drop got=%h exp=%h", obs, e_zero);
      end
      @(negedge clk); mem_ack = 1'b1; #1;
      checks++;
      if (obs !== e_zero) begin
         errors++; $display("FAIL reset_ack_ignored got=%h exp=%h", obs, e_zero);
      end
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== e_zero) begin
         errors++; $display("FAIL post_reset_idle got=%h exp=%h", obs, e_zero);
      end
      @(negedge clk); #1;
      checks++;
      if (obs !== e_fetch_ack) begin
         errors++; $display("FAIL post_reset_fetch got=%h exp=%h", obs, e_fetch_ack);
      end
   endtask

   initial begin
      e_zero           = '0;
      e_fetch_ack      = mk(1,0,0,1,1,2'b00,0,2'b01,0,3'b000,0,2'b00,2'b00,0,0);
      e_fetch_wait     = mk(1,0,0,0,0,2'b00,0,2'b01,0,3'b000,0,2'b00,2'b00,0,0);
      e_fetch_wait_ill = mk(1,0,0,0,0,2'b00,0,2'b01,0,3'b000,0,2'b00,2'b00,1,1);
      e_decode         = mk(0,0,0,0,0,2'b00,0,2'b11,1,3'b000,0,2'b00,2'b00,0,0);
      e_exec_addu      = mk(0,0,0,0,0,2'b00,1,2'b00,0,3'b000,0,2'b00,2'b00,0,0);
      e_exec_subu      = mk(0,0,0,0,0,2'b00,1,2'b00,0,3'b001,0,2'b00,2'b00,0,0);
      e_wb_r           = mk(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,2'b01,2'b00,1,0);
      e_exec_ori       = mk(0,0,0,0,0,2'b00,1,2'b10,0,3'b010,0,2'b00,2'b00,0,0);
      e_exec_lui       = mk(0,0,0,0,0,2'b00,1,2'b10,0,3'b100,0,2'b00,2'b00,0,0);
      e_wb_i           = mk(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,2'b00,2'b00,1,0);
      e_mem_addr       = mk(0,0,0,0,0,2'b00,1,2'b11,0,3'b000,0,2'b00,2'b00,0,0);
      e_mem_rd         = mk(1,0,1,0,0,2'b00,0,2'b00,0,3'b000,0,2'b00,2'b00,0,0);
      e_mem_wb         = mk(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,2'b00,2'b01,1,0);
      e_mem_wr_wait    = mk(1,1,1,0,0,2'b00,0,2'b00,0,3'b000,0,2'b00,2'b00,0,0);
      e_mem_wr_ack     = mk(1,1,1,0,0,2'b00,0,2'b00,0,3'b000,0,2'b00,2'b00,1,0);
      e_br_t           = mk(0,0,0,0,1,2'b01,1,2'b00,0,3'b001,0,2'b00,2'b00,1,0);
      e_br_n           = mk(0,0,0,0,0,2'b01,1,2'b00,0,3'b001,0,2'b00,2'b00,1,0);
      e_jump           = mk(0,0,0,0,1,2'b10,0,2'b00,0,3'b000,0,2'b00,2'b00,1,0);
      e_jal            = mk(0,0,0,0,1,2'b10,0,2'b00,0,3'b000,1,2'b10,2'b10,1,0);
      e_jr             = mk(0,0,0,0,1,2'b11,0,2'b00,0,3'b000,0,2'b00,2'b00,1,0);

      test_reset();
      test_addu();
      test_rtype_itype();
      test_lw_stall();
      test_sw_fetch_stall();
      test_beq();
      test_jumps();
      test_illegal();
      test_reset_mid_store();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
